ipd_inst_queue: RTL and testbench
=================================

IPD_INST_QUEUE -- requirements
Module: ipd_inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered instruction entries (power of two, 2..16).
REQ-002 SHALL have parameter PC_W, default 32, width of PC and predicted-PC fields.
REQ-003 SHALL have ports: clk in 1 clock; reset in 1 synchronous active-high reset.
REQ-004 SHALL have ports: if_valid in 1 fetch packet offered; if_pc in PC_W fetch PC; if_pred_pc in PC_W predicted next PC; ipd_allow_in out 1 queue can accept.
REQ-005 SHALL have port inst_ram_r_data in 32: instruction word, valid in the cycle after the accepting handshake.
REQ-006 SHALL have ports: br_cancel in 1 flush request from ID; id_allow_in in 1 ID can accept.
REQ-007 SHALL have outputs: id_valid 1; id_inst_type 26; id_pred_pc PC_W; id_pc PC_W; id_imm 32; id_rf_waddr 5; id_rf_raddr2 5; id_rf_raddr1 5.

Function
REQ-008 SHALL accept a packet when if_valid & ipd_allow_in & ~br_cancel; {if_pc, if_pred_pc} written to tail entry, tail advances modulo DEPTH.
REQ-009 SHALL capture inst_ram_r_data into the entry accepted in the previous cycle; the entry becomes ready only then.
REQ-010 SHALL drive ipd_allow_in = (occupied entries, including one awaiting its inst) < DEPTH, purely from registered state.
REQ-011 SHALL drive id_valid = head entry ready; head pops when id_valid & id_allow_in, head advances modulo DEPTH.
REQ-012 SHALL hold all id_* outputs stable while id_valid & ~id_allow_in.
REQ-013 SHALL decode the head entry combinationally: id_inst_type one-hot, bit 25..0 = addi.w, add.w, sub.w, or, ori, nor, andi, and, xor, srli.w, slli.w, srai.w, lu12i.w, pcaddu12i, slt, sltu, mul.w, jirl, b, beq, bne, bl, st.w, ld.w, st.b, ld.b (LA32R encodings); unknown opcode gives all-zero type.
REQ-014 SHALL select raddr1/raddr2 = rk/rj for 3-register ALU ops and mul.w; raddr1 = rj for imm-ALU, jirl, branches, loads, stores; raddr2 = rd for beq, bne, st.w, st.b; otherwise 0.
REQ-015 SHALL set waddr = rd for all ALU, mul.w, jirl, ld.w, ld.b; 0 otherwise (bl writes r1 via ID, not here).
REQ-016 SHALL form id_imm: sext si12 (addi.w, loads, stores); zext ui12 (ori, andi); zext ui5 (shifts); {si20,12'b0} (lu12i.w, pcaddu12i); sext {offs16,2'b0} (jirl, beq, bne); sext {offs26,2'b0} (b, bl); else 0.
REQ-017 SHALL on br_cancel: empty queue next cycle (head=tail, count 0), discard any inst arriving next cycle, refuse acceptance that cycle; simultaneous pop is void.
REQ-018 SHALL allow simultaneous accept and pop when full-minus-one or empty-with-ready head; count unchanged.
REQ-019 SHALL never overwrite an unpopped entry; accept while full is impossible by REQ-010.

Reset
REQ-020 SHALL on reset clear head, tail, count, pending-inst flag, entry ready bits; id_valid=0, ipd_allow_in=1 in the following cycle; outputs other than id_valid are don't-care while id_valid=0.
REQ-021 SHALL treat reset mid-operation as REQ-020; inst arriving the cycle after reset is discarded.

Configuration
REQ-022 SHALL provide macro IPD_QUEUE_BYPASS_EN.
REQ-023 Without it: inst arrival to id_valid latency is 1 cycle.
REQ-024 With it: when queue holds only the awaiting entry, id_valid=1 in the arrival cycle, decoding inst_ram_r_data directly; if popped that cycle the entry is freed without storage; otherwise behaves as without.

Verification
REQ-025 Reset then idle: id_valid=0, ipd_allow_in=1 every cycle.
REQ-026 Single addi.w r5,r6,-1 (0x02BFFCC5) at PC 0x1C000000, id_allow_in=1: id_valid 1 cycle after inst (0 with bypass), type bit25, raddr1=6, waddr=5, imm=0xFFFFFFFF.
REQ-027 id_allow_in=0, stream 5 packets, DEPTH=4: exactly 4 accepted, ipd_allow_in=0 after 4th; release stall -> PCs pop in order, no loss.
REQ-028 br_cancel while 3 entries buffered and 1 inst pending: next cycle id_valid=0, count 0; late inst ignored; next packet pops alone.
REQ-029 beq r4,r7,-8: raddr1=4, raddr2=7, waddr=0, imm=0xFFFFFFF8; bl +0x100: imm=0x00000100, waddrs 0.
REQ-030 Wrap: 10 back-to-back packets with continuous pop: order preserved across pointer wrap, one pop per cycle steady state.

Source files
------------

// File: rtl/ipd_inst_queue.sv
// Instruction pre-decode queue between fetch and ID: buffers {pc, pred_pc, inst}, decodes the head entry.
// Build option IPD_QUEUE_BYPASS_EN: present an arriving instruction to ID in its arrival cycle when the queue holds only that entry.
module ipd_inst_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [PC_W-1:0] if_pc,
    input  logic [PC_W-1:0] if_pred_pc,
    output logic            ipd_allow_in,
    input  logic [31:0]     inst_ram_r_data,
    input  logic            br_cancel,
    input  logic            id_allow_in,
    output logic            id_valid,
    output logic [25:0]     id_inst_type,
    output logic [PC_W-1:0] id_pred_pc,
    output logic [PC_W-1:0] id_pc,
    output logic [31:0]     id_imm,
    output logic [4:0]      id_rf_waddr,
    output logic [4:0]      id_rf_raddr2,
    output logic [4:0]      id_rf_raddr1
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, pend_idx_q, pend_idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pend_q, pend_d;
    logic [DEPTH-1:0] rdy_q, rdy_d;
    logic [PC_W-1:0]  pc_q   [DEPTH];
    logic [PC_W-1:0]  pc_d   [DEPTH];
    logic [PC_W-1:0]  pred_q [DEPTH];
    logic [PC_W-1:0]  pred_d [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [31:0]      inst_d [DEPTH];

    logic        accept, pop, byp;
    logic [31:0] head_inst;

    assign ipd_allow_in = (count_q < DEPTH_C);
    assign accept       = if_valid & ipd_allow_in & ~br_cancel;

`ifdef IPD_QUEUE_BYPASS_EN
    // The awaiting entry is the head only when it is the sole occupant.
    assign byp = pend_q & (pend_idx_q == head_q) & ~rdy_q[head_q];
`else
    assign byp = 1'b0;
`endif

    assign id_valid  = rdy_q[head_q] | byp;
    assign pop       = id_valid & id_allow_in & ~br_cancel;
    assign head_inst = byp ? inst_ram_r_data : inst_q[head_q];

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        pend_d     = 1'b0;
        pend_idx_d = pend_idx_q;
        rdy_d      = rdy_q;
        pc_d       = pc_q;
        pred_d     = pred_q;
        inst_d     = inst_q;

        // A bypassed entry popped in its arrival cycle is never stored.
        if (pend_q && !(byp && pop)) begin
            inst_d[pend_idx_q] = inst_ram_r_data;
            rdy_d[pend_idx_q]  = 1'b1;
        end
        if (pop) begin
            rdy_d[head_q] = 1'b0;
            head_d        = head_q + PTR_W'(1);
        end
        if (accept) begin
            pc_d[tail_q]   = if_pc;
            pred_d[tail_q] = if_pred_pc;
            rdy_d[tail_q]  = 1'b0;
            tail_d         = tail_q + PTR_W'(1);
            pend_d         = 1'b1;
            pend_idx_d     = tail_q;
        end
        count_d = count_q + CNT_W'(accept) - CNT_W'(pop);

        if (br_cancel) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pend_d  = 1'b0;
            rdy_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            rdy_q      <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            rdy_q      <= rdy_d;
        end
        pc_q   <= pc_d;
        pred_q <= pred_d;
        inst_q <= inst_d;
    end

    function automatic logic [25:0] dec_type(input logic [31:0] i);
        logic [25:0] t;
        t     = '0;
        t[25] = (i[31:22] == 10'h00A);  // addi.w
        t[24] = (i[31:15] == 17'h00020);
        t[23] = (i[31:15] == 17'h00022);
        t[22] = (i[31:15] == 17'h0002A);
        t[21] = (i[31:22] == 10'h00E);  // ori
        t[20] = (i[31:15] == 17'h00028);
        t[19] = (i[31:22] == 10'h00D);  // andi
        t[18] = (i[31:15] == 17'h00029);
        t[17] = (i[31:15] == 17'h0002B);
        t[16] = (i[31:15] == 17'h00089);
        t[15] = (i[31:15] == 17'h00081);
        t[14] = (i[31:15] == 17'h00091);
        t[13] = (i[31:25] == 7'h0A);
        t[12] = (i[31:25] == 7'h0E);
        t[11] = (i[31:15] == 17'h00024);
        t[10] = (i[31:15] == 17'h00025);
        t[9]  = (i[31:15] == 17'h00038);
        t[8]  = (i[31:26] == 6'h13);
        t[7]  = (i[31:26] == 6'h14);
        t[6]  = (i[31:26] == 6'h16);
        t[5]  = (i[31:26] == 6'h17);
        t[4]  = (i[31:26] == 6'h15);
        t[3]  = (i[31:22] == 10'h0A6);
        t[2]  = (i[31:22] == 10'h0A2);
        t[1]  = (i[31:22] == 10'h0A4);
        t[0]  = (i[31:22] == 10'h0A0);
        return t;
    endfunction

    function automatic logic [31:0] dec_imm(input logic [31:0] i, input logic [25:0] t);
        if (t[25] || (|t[3:0]))      return {{20{i[21]}}, i[21:10]};
        if (t[21] || t[19])          return {20'b0, i[21:10]};
        if (t[16] || t[15] || t[14]) return {27'b0, i[14:10]};
        if (t[13] || t[12])          return {i[24:5], 12'b0};
        if (t[8] || t[6] || t[5])    return {{14{i[25]}}, i[25:10], 2'b00};
        if (t[7] || t[4])            return {{4{i[9]}}, i[9:0], i[25:10], 2'b00};
        return 32'b0;
    endfunction

    logic alu3, alui, rd_src1, rd_src2, wr_rd;

    always_comb begin
        id_inst_type = dec_type(head_inst);
        alu3    = |{id_inst_type[24:22], id_inst_type[20], id_inst_type[18:17], id_inst_type[11:9]};
        alui    = |{id_inst_type[25], id_inst_type[21], id_inst_type[19], id_inst_type[16:14]};
        rd_src1 = alui | id_inst_type[8] | id_inst_type[6] | id_inst_type[5] | (|id_inst_type[3:0]);
        rd_src2 = id_inst_type[6] | id_inst_type[5] | id_inst_type[3] | id_inst_type[1];
        wr_rd   = alu3 | alui | id_inst_type[13] | id_inst_type[12] | id_inst_type[8]
                | id_inst_type[2] | id_inst_type[0];

        id_rf_raddr1 = alu3 ? head_inst[14:10] : (rd_src1 ? head_inst[9:5] : 5'd0);
        id_rf_raddr2 = alu3 ? head_inst[9:5]   : (rd_src2 ? head_inst[4:0] : 5'd0);
        id_rf_waddr  = wr_rd ? head_inst[4:0] : 5'd0;
        id_imm       = dec_imm(head_inst, id_inst_type);
    end

    assign id_pc      = pc_q[head_q];
    assign id_pred_pc = pred_q[head_q];

endmodule

// File: tb/tb_ipd_inst_queue.sv
// Directed bench for ipd_inst_queue: decode vectors, backpressure, flush, reset and pointer wrap.
module tb_ipd_inst_queue;
    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pred_pc;
    logic        ipd_allow_in;
    logic [31:0] inst_ram_r_data;
    logic        br_cancel;
    logic        id_allow_in;
    logic        id_valid;
    logic [25:0] id_inst_type;
    logic [31:0] id_pred_pc;
    logic [31:0] id_pc;
    logic [31:0] id_imm;
    logic [4:0]  id_rf_waddr;
    logic [4:0]  id_rf_raddr2;
    logic [4:0]  id_rf_raddr1;

    int err_cnt = 0;
    int chk_cnt = 0;

`ifdef IPD_QUEUE_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    ipd_inst_queue #(.DEPTH(4), .PC_W(32)) dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_pc(if_pc), .if_pred_pc(if_pred_pc), .ipd_allow_in(ipd_allow_in),
        .inst_ram_r_data(inst_ram_r_data), .br_cancel(br_cancel), .id_allow_in(id_allow_in),
        .id_valid(id_valid), .id_inst_type(id_inst_type), .id_pred_pc(id_pred_pc), .id_pc(id_pc),
        .id_imm(id_imm), .id_rf_waddr(id_rf_waddr), .id_rf_raddr2(id_rf_raddr2), .id_rf_raddr1(id_rf_raddr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        case (pc)
            32'h1C000000: return 32'h02BFFCC5;  // addi.w r5,r6,-1
            32'h1C000100: return 32'h5BFFF887;  // beq r4,r7,-8
            32'h1C000200: return 32'h54010000;  // bl +0x100
            32'h1C000300: return 32'h00100823;  // add.w r3,r1,r2
            32'h1C000400: return 32'h29804107;  // st.w r7,r8,16
            32'h1C000500: return 32'hFFFFFFFF;  // unknown
            default:      return 32'h02800000 | {10'b0, pc[13:2], 10'b0};
        endcase
    endfunction

    // Instruction RAM: returns the word for the PC offered in the previous cycle.
    task automatic tick();
        logic [31:0] pc_prev;
        pc_prev = if_pc;
        @(posedge clk);
        #1;
        inst_ram_r_data = inst_of(pc_prev);
    endtask

    task automatic send_one(input logic [31:0] pc);
        if_valid   = 1'b1;
        if_pc      = pc;
        if_pred_pc = pc + 32'd4;
        tick();
        if_valid = 1'b0;
        if (LAT == 2) tick();
        #1;
    endtask

    task automatic check_dec(input string tag, input logic [31:0] pc, input logic [25:0] ty,
                             input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] wa,
                             input logic [31:0] imm);
        check({tag, "_valid"}, 32'(id_valid), 32'd1);
        check({tag, "_pc"}, id_pc, pc);
        check({tag, "_pred"}, id_pred_pc, pc + 32'd4);
        check({tag, "_type"}, 32'(id_inst_type), 32'(ty));
        check({tag, "_raddr1"}, 32'(id_rf_raddr1), 32'(r1));
        check({tag, "_raddr2"}, 32'(id_rf_raddr2), 32'(r2));
        check({tag, "_waddr"}, 32'(id_rf_waddr), 32'(wa));
        check({tag, "_imm"}, id_imm, imm);
        tick();
        #1;
        check({tag, "_gone"}, 32'(id_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; if_valid = 1'b0; if_pc = 32'h0; if_pred_pc = 32'h0;
        inst_ram_r_data = 32'h0; br_cancel = 1'b0; id_allow_in = 1'b1;
        tick(); tick();
        reset = 1'b0;

        for (int k = 0; k < 3; k++) begin
            #1;
            check("idle_valid", 32'(id_valid), 32'd0);
            check("idle_allow", 32'(ipd_allow_in), 32'd1);
            tick();
        end

        send_one(32'h1C000000);
        check_dec("addi", 32'h1C000000, 26'h2000000, 5'd6, 5'd0, 5'd5, 32'hFFFFFFFF);
        send_one(32'h1C000100);
        check_dec("beq", 32'h1C000100, 26'h0000040, 5'd4, 5'd7, 5'd0, 32'hFFFFFFF8);
        send_one(32'h1C000200);
        check_dec("bl", 32'h1C000200, 26'h0000010, 5'd0, 5'd0, 5'd0, 32'h00000100);
        send_one(32'h1C000300);
        check_dec("add", 32'h1C000300, 26'h1000000, 5'd2, 5'd1, 5'd3, 32'h00000000);
        send_one(32'h1C000400);
        check_dec("stw", 32'h1C000400, 26'h0000008, 5'd8, 5'd7, 5'd0, 32'h00000010);
        send_one(32'h1C000500);
        check("unk_valid", 32'(id_valid), 32'd1);
        check("unk_type", 32'(id_inst_type), 32'd0);
        tick();

        // Backpressure: four accepted, fifth held until ID drains.
        for (int k = 0; k < 12; k++) begin
            int idx;
            logic exp_allow, exp_valid;
            if_valid    = (k < 8);
            if_pc       = 32'h1C001000 + 32'(4 * ((k < 5) ? k : 4));
            if_pred_pc  = if_pc + 32'd4;
            id_allow_in = (k >= 6);
            exp_allow   = (k < 4) || (k >= 7);
            exp_valid   = (k == 1) ? (LAT == 1) : ((k >= 2) && (k <= 10));
            idx         = (k <= 6) ? 0 : k - 6;
            #1;
            check("stall_allow", 32'(ipd_allow_in), 32'(exp_allow));
            check("stall_valid", 32'(id_valid), 32'(exp_valid));
            if (exp_valid) check("stall_pc", id_pc, 32'h1C001000 + 32'(4 * idx));
            tick();
        end

        // Flush with three ready entries and one awaiting its instruction.
        id_allow_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if_valid = 1'b1;
            if_pc    = 32'h1C003000 + 32'(4 * k);
            #1;
            check("fill_allow", 32'(ipd_allow_in), 32'd1);
            tick();
        end
        if_valid = 1'b1; if_pc = 32'h1C003040; br_cancel = 1'b1;
        #1;
        check("cancel_full", 32'(ipd_allow_in), 32'd0);
        tick();
        br_cancel = 1'b0; if_valid = 1'b0;
        #1;
        check("cancel_valid", 32'(id_valid), 32'd0);
        check("cancel_allow", 32'(ipd_allow_in), 32'd1);
        tick();
        #1;
        check("cancel_late", 32'(id_valid), 32'd0);
        tick();

        // A packet offered in the flush cycle is refused.
        id_allow_in = 1'b1;
        if_valid = 1'b1; if_pc = 32'h1C004000; br_cancel = 1'b1;
        tick();
        br_cancel = 1'b0; if_valid = 1'b0;
        #1;
        check("refuse_v1", 32'(id_valid), 32'd0);
        tick();
        #1;
        check("refuse_v2", 32'(id_valid), 32'd0);
        check("refuse_cnt", 32'(ipd_allow_in), 32'd1);
        send_one(32'h1C005000);
        check("after_cancel_pc", id_pc, 32'h1C005000);
        check("after_cancel_valid", 32'(id_valid), 32'd1);
        tick();
        #1;
        check("after_cancel_alone", 32'(id_valid), 32'd0);

        // Reset while entries are buffered and an instruction is arriving.
        id_allow_in = 1'b0;
        if_valid = 1'b1; if_pc = 32'h1C006000;
        tick();
        if_pc = 32'h1C006004;
        tick();
        if_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst_mid_valid", 32'(id_valid), 32'd0);
        check("rst_mid_allow", 32'(ipd_allow_in), 32'd1);
        tick();
        #1;
        check("rst_mid_late", 32'(id_valid), 32'd0);
        tick();

        // Ten back-to-back packets with continuous pop across pointer wrap.
        id_allow_in = 1'b1;
        for (int k = 0; k < 14; k++) begin
            logic exp_valid;
            if_valid   = (k < 10);
            if_pc      = 32'h1C002000 + 32'(4 * ((k < 10) ? k : 9));
            if_pred_pc = if_pc + 32'd4;
            exp_valid  = (k >= LAT) && (k <= LAT + 9);
            #1;
            check("wrap_allow", 32'(ipd_allow_in), 32'd1);
            check("wrap_valid", 32'(id_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("wrap_pc", id_pc, 32'h1C002000 + 32'(4 * (k - LAT)));
                check("wrap_pred", id_pred_pc, 32'h1C002004 + 32'(4 * (k - LAT)));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
